umi_mem_target: RTL and testbench



---
 rtl/umi_mem_target_pkg.sv | 84 ++++++++
 rtl/umi_mem_ram.sv | 36 +++
 rtl/umi_mem_target.sv | 174 +++++++++++++++++
 tb/tb_umi_mem_target.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/umi_mem_target_pkg.sv
// Shared definitions for the UMI target memory.
//
// Contents:
//   - UMI opcodes WRITE_POSTED, READ_REQUEST and WRITE_RESPONSE.
//   - Error codes UMI_MEM_ERR_NONE/OPCODE/SIZE/RANGE.
//   - FSM state type.
//   - umi_pack / umi_unpack helpers and the field struct they use.
//
// Optional feature macro: UMI_MEM_RD_LATENCY_EN adds the WAIT state.
//
// Packet layout (256 bits):
//   [7:0]     opcode
//   [11:8]    size (log2 of bytes per beat)
//   [15:12]   options
//   [16]      burst
//   [31:17]   reserved, zero
//   [63:32]   dstaddr
//   [95:64]   srcaddr
//   [223:96]  data
//   [255:224] reserved, zero
// Addresses are carried as 32 bits on the wire and widened to 64 bits on unpack.
package umi_mem_target_pkg;

    localparam logic [7:0] WRITE_POSTED   = 8'h01;
    localparam logic [7:0] READ_REQUEST   = 8'h02;
    localparam logic [7:0] WRITE_RESPONSE = 8'h03;

    localparam logic [1:0] UMI_MEM_ERR_NONE   = 2'd0;
    localparam logic [1:0] UMI_MEM_ERR_OPCODE = 2'd1;
    localparam logic [1:0] UMI_MEM_ERR_SIZE   = 2'd2;
    localparam logic [1:0] UMI_MEM_ERR_RANGE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef UMI_MEM_RD_LATENCY_EN
        WAIT = 2'd2,
`endif
        RESP = 2'd1
    } state_t;

    typedef struct packed {
        logic [7:0]   opcode;
        logic [3:0]   size;
        logic [3:0]   options;
        logic         burst;
        logic [63:0]  dstaddr;
        logic [63:0]  srcaddr;
        logic [127:0] data;
    } umi_fields_t;

    function automatic umi_fields_t umi_unpack(input logic [255:0] p);
        umi_fields_t f;
        f.opcode  = p[7:0];
        f.size    = p[11:8];
        f.options = p[15:12];
        f.burst   = p[16];
        f.dstaddr = {32'd0, p[63:32]};
        f.srcaddr = {32'd0, p[95:64]};
        f.data    = p[223:96];
        return f;
    endfunction

    function automatic logic [255:0] umi_pack(
        input logic [7:0]   opcode,
        input logic [3:0]   size,
        input logic [3:0]   options,
        input logic         burst,
        input logic [63:0]  dstaddr,
        input logic [63:0]  srcaddr,
        input logic [127:0] data
    );
        logic [255:0] p;
        p          = '0;
        p[7:0]     = opcode;
        p[11:8]    = size;
        p[15:12]   = options;
        p[16]      = burst;
        p[63:32]   = dstaddr[31:0];
        p[95:64]   = srcaddr[31:0];
        p[223:96]  = data;
        return p;
    endfunction

endpackage

// File: rtl/umi_mem_ram.sv
// Single-port synchronous RAM, DW x DEPTH, with write enable and a registered
// read port. The read register only updates when re is high, so the last read
// word is held for as long as the caller needs it. Contents are not reset.
//
// Ports:
//   clk   - clock
//   we    - write enable (writes wdata at addr)
//   re    - read enable (loads rdata from addr)
//   addr  - word address
//   wdata - write data
//   rdata - registered read data
module umi_mem_ram #(
    parameter int DW    = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/umi_mem_target.sv
// UMI target memory. Accepts posted writes and read requests on the request
// port, services them against an internal word-addressed RAM, and returns read
// data as WRITE_RESPONSE packets on the response port. One request is in
// flight at a time.
//
// Optional feature macro: UMI_MEM_RD_LATENCY_EN adds a WAIT state and an 8-bit
// down-counter that delays every read response by RD_LATENCY cycles.
//
// Handshake: on both ports a transfer happens on a rising clk edge where valid
// and ready are both high; the packet must be held stable while valid is high.
//
// Ports:
//   clk, nreset      - clock, synchronous active-low reset
//   umi_req_*        - request stream in (packet, valid, ready)
//   umi_resp_*       - response stream out (packet, valid, ready)
//   err_sticky       - a malformed request has been seen since reset
//   err_code         - code of the first error seen
module umi_mem_target
    import umi_mem_target_pkg::*;
#(
    parameter int          DW         = 32,
    parameter int          DEPTH      = 1024,
    parameter logic [63:0] BASE_ADDR  = 64'h0,
    parameter int          RD_LATENCY = 4
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic [255:0] umi_req_packet,
    input  logic         umi_req_valid,
    output logic         umi_req_ready,
    output logic [255:0] umi_resp_packet,
    output logic         umi_resp_valid,
    input  logic         umi_resp_ready,
    output logic         err_sticky,
    output logic [1:0]   err_code
);

    localparam int          AW         = $clog2(DEPTH);
    localparam int          LSB        = $clog2(DW / 8);
    localparam logic [3:0]  LEGAL_SIZE = 4'(LSB);
    localparam logic [63:0] SPAN       = 64'(DEPTH) * 64'(DW / 8);

    state_t        state;
    state_t        state_next;
    umi_fields_t   req;
    logic [63:0]   offset;
    logic [AW-1:0] word_idx;
    logic          accept;
    logic          is_write;
    logic          is_read;
    logic          bad_op;
    logic          bad_size;
    logic          in_range;
    logic          ram_we;
    logic          ram_re;
    logic          rd_start;
    logic          err_now;
    logic [1:0]    err_now_code;
    logic [DW-1:0] ram_rdata;
    logic [63:0]   resp_dstaddr;
    logic          resp_zero;
    logic [127:0]  resp_data;

    assign req      = umi_unpack(umi_req_packet);
    assign offset   = req.dstaddr - BASE_ADDR;
    assign word_idx = offset[LSB +: AW];
    assign accept   = umi_req_valid && umi_req_ready;
    assign is_write = (req.opcode == WRITE_POSTED);
    assign is_read  = (req.opcode == READ_REQUEST);
    assign bad_op   = !(is_write || is_read);
    assign bad_size = (req.size != LEGAL_SIZE) || req.burst;
    assign in_range = (req.dstaddr >= BASE_ADDR) && (offset < SPAN);

    assign ram_we   = accept && is_write && !bad_size && in_range;
    assign ram_re   = accept && is_read && !bad_size && in_range;
    // Reads with a legal shape always answer, even out of range, so the
    // requester never hangs; out-of-range reads answer with zero data.
    assign rd_start = accept && is_read && !bad_size;

    assign err_now      = accept && (bad_op || bad_size || !in_range);
    assign err_now_code = bad_op   ? UMI_MEM_ERR_OPCODE :
                          bad_size ? UMI_MEM_ERR_SIZE   : UMI_MEM_ERR_RANGE;

    umi_mem_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (word_idx),
        .wdata (req.data[DW-1:0]),
        .rdata (ram_rdata)
    );

`ifdef UMI_MEM_RD_LATENCY_EN
    logic [7:0] lat_cnt;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            lat_cnt <= 8'd0;
        end else if (rd_start) begin
            lat_cnt <= 8'(RD_LATENCY);
        end else if (state == WAIT) begin
            lat_cnt <= lat_cnt - 8'd1;
        end
    end
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rd_start) begin
`ifdef UMI_MEM_RD_LATENCY_EN
                    state_next = (RD_LATENCY > 0) ? WAIT : RESP;
`else
                    state_next = RESP;
`endif
                end
            end
`ifdef UMI_MEM_RD_LATENCY_EN
            WAIT: begin
                // The counter reaches zero on this edge.
                if (lat_cnt == 8'd1) begin
                    state_next = RESP;
                end
            end
`endif
            RESP: begin
                if (umi_resp_valid && umi_resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state          <= IDLE;
            umi_req_ready  <= 1'b0;
            umi_resp_valid <= 1'b0;
            resp_dstaddr   <= 64'd0;
            resp_zero      <= 1'b0;
            err_sticky     <= 1'b0;
            err_code       <= UMI_MEM_ERR_NONE;
        end else begin
            state          <= state_next;
            // Ready re-opens one cycle after the FSM settles back in IDLE,
            // giving 1 read per 3 cycles with the response port always ready.
            umi_req_ready  <= (state == IDLE) && (state_next == IDLE);
            umi_resp_valid <= (state_next == RESP);
            if (rd_start) begin
                resp_dstaddr <= req.srcaddr;
                resp_zero    <= !in_range;
            end
            if (err_now && !err_sticky) begin
                err_sticky <= 1'b1;
                err_code   <= err_now_code;
            end
        end
    end

    // The RAM read register and the latched address are both held for the
    // whole response, so the packet is stable while valid is high; it reads
    // as zero whenever no response is pending.
    assign resp_data       = resp_zero ? 128'd0 : 128'(ram_rdata);
    assign umi_resp_packet = umi_resp_valid ?
                             umi_pack(WRITE_RESPONSE, LEGAL_SIZE, 4'd0, 1'b0,
                                      resp_dstaddr, 64'd0, resp_data) : 256'd0;

endmodule

// File: tb/tb_umi_mem_target.sv
// Self-checking bench for umi_mem_target: directed cases plus a randomized
// write/read mix checked against an associative-array memory model, an
// expected-response queue and a first-error model.
module tb_umi_mem_target;

  localparam int          DW     = 32;
  localparam int          DEPTH  = 256;
  localparam logic [63:0] BASE   = 64'h2000;
  localparam int          RD_LAT = 4;
  localparam logic [31:0] BASE32 = 32'h2000;
  localparam logic [31:0] SPAN   = 32'(DEPTH * DW / 8);
`ifdef UMI_MEM_RD_LATENCY_EN
  localparam int EXP_LAT = RD_LAT;
`else
  localparam int EXP_LAT = 0;
`endif

  logic         clk;
  logic         nreset;
  logic [255:0] umi_req_packet;
  logic         umi_req_valid;
  logic         umi_req_ready;
  logic [255:0] umi_resp_packet;
  logic         umi_resp_valid;
  logic         umi_resp_ready;
  logic         err_sticky;
  logic [1:0]   err_code;

  umi_mem_target #(
    .DW         (DW),
    .DEPTH      (DEPTH),
    .BASE_ADDR  (BASE),
    .RD_LATENCY (RD_LAT)
  ) dut (
    .clk             (clk),
    .nreset          (nreset),
    .umi_req_packet  (umi_req_packet),
    .umi_req_valid   (umi_req_valid),
    .umi_req_ready   (umi_req_ready),
    .umi_resp_packet (umi_resp_packet),
    .umi_resp_valid  (umi_resp_valid),
    .umi_resp_ready  (umi_resp_ready),
    .err_sticky      (err_sticky),
    .err_code        (err_code)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int             checks   = 0;
  int             failures = 0;
  logic [DW-1:0]  mem_model [int];
  logic [255:0]   exp_q [$];
  logic [31:0]    written_q [$];
  logic           exp_sticky;
  logic [1:0]     exp_code;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Packet as seen on the wire: opcode[7:0], size[11:8], burst[16],
  // dstaddr[63:32], srcaddr[95:64], data[223:96].
  function automatic logic [255:0] mk_pkt(input logic [7:0] op, input logic [3:0] size,
                                          input logic burst, input logic [31:0] dst,
                                          input logic [31:0] src, input logic [127:0] data);
    logic [255:0] p;
    p          = '0;
    p[7:0]     = op;
    p[11:8]    = size;
    p[16]      = burst;
    p[63:32]   = dst;
    p[95:64]   = src;
    p[223:96]  = data;
    return p;
  endfunction

  function automatic bit addr_ok(input logic [31:0] a);
    return (a >= BASE32) && (a < BASE32 + SPAN);
  endfunction

  function automatic int word_key(input logic [31:0] a);
    return int'((a - BASE32) >> 2);
  endfunction

  task automatic note_err(input logic [1:0] code);
    if (!exp_sticky) begin
      exp_sticky = 1'b1;
      exp_code   = code;
    end
  endtask

  task automatic check_err(input string tag);
    check_eq({tag, "_sticky"}, 256'(err_sticky), 256'(exp_sticky));
    check_eq({tag, "_code"}, 256'(err_code), 256'(exp_code));
  endtask

  // ---------------- driver tasks ----------------
  // Called #1 after a clock edge; returns #1 after the edge that took the packet.
  task automatic send_req(input logic [255:0] pkt);
    bit got;
    int n;
    got = 1'b0;
    n   = 0;
    umi_req_packet = pkt;
    umi_req_valid  = 1'b1;
    while (!got && n < 50) begin
      got = umi_req_ready;
      @(posedge clk); #1;
      n++;
    end
    umi_req_valid  = 1'b0;
    umi_req_packet = '0;
    check_eq("req_accept", 256'(got), 256'(1));
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [DW-1:0] data,
                          input logic [3:0] size, input logic burst);
    send_req(mk_pkt(8'h01, size, burst, addr, 32'h0, 128'(data)));
    if (size != 4'd2 || burst) note_err(2'd2);
    else if (!addr_ok(addr)) note_err(2'd3);
    else mem_model[word_key(addr)] = data;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] src, input int hold);
    logic [DW-1:0] exp_data;
    logic [255:0]  first;
    logic [255:0]  seen;
    if (addr_ok(addr)) begin
      exp_data = mem_model[word_key(addr)];
    end else begin
      exp_data = '0;
      note_err(2'd3);
    end
    exp_q.push_back(mk_pkt(8'h03, 4'd2, 1'b0, src, 32'h0, 128'(exp_data)));
    send_req(mk_pkt(8'h02, 4'd2, 1'b0, addr, src, 128'h0));
    for (int i = 0; i < EXP_LAT; i++) begin
      check_eq("resp_valid_early", 256'(umi_resp_valid), 256'(0));
      @(posedge clk); #1;
    end
    check_eq("resp_valid_rise", 256'(umi_resp_valid), 256'(1));
    check_eq("req_ready_busy", 256'(umi_req_ready), 256'(0));
    first = umi_resp_packet;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("resp_hold_pkt", umi_resp_packet, first);
      check_eq("resp_hold_valid", 256'(umi_resp_valid), 256'(1));
      check_eq("resp_hold_ready", 256'(umi_req_ready), 256'(0));
    end
    umi_resp_ready = 1'b1;
    seen = umi_resp_packet;
    @(posedge clk); #1;
    umi_resp_ready = 1'b0;
    check_eq("resp_pkt", seen, exp_q.pop_front());
    check_eq("resp_valid_drop", 256'(umi_resp_valid), 256'(0));
    check_eq("req_ready_gap", 256'(umi_req_ready), 256'(0));
    @(posedge clk); #1;
    check_eq("req_ready_back", 256'(umi_req_ready), 256'(1));
    check_err("read");
  endtask

  // Posted writes with valid held high: each must go in on consecutive edges.
  task automatic write_b2b(input logic [31:0] a0, input logic [DW-1:0] d0,
                           input logic [31:0] a1, input logic [DW-1:0] d1,
                           input logic [31:0] a2, input logic [DW-1:0] d2);
    logic [31:0]   a [3];
    logic [DW-1:0] d [3];
    a[0] = a0; a[1] = a1; a[2] = a2;
    d[0] = d0; d[1] = d1; d[2] = d2;
    umi_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      umi_req_packet = mk_pkt(8'h01, 4'd2, 1'b0, a[i], 32'h0, 128'(d[i]));
      check_eq("b2b_ready", 256'(umi_req_ready), 256'(1));
      mem_model[word_key(a[i])] = d[i];
      @(posedge clk); #1;
    end
    umi_req_valid  = 1'b0;
    umi_req_packet = '0;
  endtask

  task automatic expect_silent(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      check_eq(tag, 256'(umi_resp_valid), 256'(0));
    end
    check_eq({tag, "_ready"}, 256'(umi_req_ready), 256'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] ra;
    nreset         = 1'b0;
    umi_req_valid  = 1'b0;
    umi_req_packet = '0;
    umi_resp_ready = 1'b0;
    exp_sticky     = 1'b0;
    exp_code       = 2'd0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req_ready", 256'(umi_req_ready), 256'(0));
    check_eq("rst_resp_valid", 256'(umi_resp_valid), 256'(0));
    check_eq("rst_resp_pkt", umi_resp_packet, 256'(0));
    check_err("rst");
    nreset = 1'b1;
    check_eq("ready_before_release_edge", 256'(umi_req_ready), 256'(0));
    @(posedge clk); #1;
    check_eq("ready_after_release", 256'(umi_req_ready), 256'(1));

    // Basic write then read back, response addressed to the request srcaddr.
    do_write(BASE32 + 32'h10, 32'h1234_5678, 4'd2, 1'b0);
    check_err("write");
    do_read(BASE32 + 32'h10, BASE32 + 32'h10, 0);

    // Back-to-back posted writes, then read each.
    write_b2b(BASE32 + 32'h0, 32'hA5A5_0001, BASE32 + 32'h4, 32'h5A5A_0002,
              BASE32 + 32'h8, 32'h0F0F_0003);
    do_read(BASE32 + 32'h0, 32'h0000_1111, 0);
    do_read(BASE32 + 32'h4, 32'h0000_2222, 1);
    do_read(BASE32 + 32'h8, 32'h0000_3333, 0);

    // Response held off for 5 cycles.
    do_read(BASE32 + 32'h10, 32'h00C0_FFEE, 5);

    // Low address bits are ignored; top word of the RAM is reachable.
    do_write(BASE32 + 32'h23, 32'hBEEF_0023, 4'd2, 1'b0);
    do_read(BASE32 + 32'h20, 32'h0000_0020, 0);
    do_write(BASE32 + SPAN - 32'h4, 32'h7777_8888, 4'd2, 1'b0);
    do_read(BASE32 + SPAN - 32'h1, 32'h0000_0abc, 0);

    // Randomized mix of in-range writes and reads of written words.
    for (int it = 0; it < 30; it++) begin
      if (written_q.size() == 0 || $urandom_range(0, 1) == 0) begin
        ra = BASE32 + (32'($urandom_range(0, DEPTH - 1)) << 2);
        written_q.push_back(ra);
        do_write(ra + 32'($urandom_range(0, 3)), $urandom, 4'd2, 1'b0);
      end else begin
        ra = written_q[$urandom_range(0, written_q.size() - 1)];
        do_read(ra + 32'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3));
      end
    end
    check_err("random");

    // Out-of-range read answers with zero data and records a range error.
    do_read(BASE32 + SPAN, 32'h0000_0444, 0);
    // Later errors keep the first code.
    send_req(mk_pkt(8'hFF, 4'd2, 1'b0, BASE32, 32'h0, 128'h0));
    note_err(2'd1);
    check_err("bad_opcode");
    expect_silent("bad_opcode_noresp", 3);
    do_read(BASE32 - 32'h4, 32'h0000_0555, 0);

    // Malformed reads produce no response; malformed writes leave RAM alone.
    send_req(mk_pkt(8'h02, 4'd3, 1'b0, BASE32 + 32'h10, 32'h1, 128'h0));
    note_err(2'd2);
    expect_silent("bad_size_read", 4);
    send_req(mk_pkt(8'h02, 4'd2, 1'b1, BASE32 + 32'h10, 32'h1, 128'h0));
    expect_silent("burst_read", 4);
    do_write(BASE32 + 32'h10, 32'hDEAD_0001, 4'd1, 1'b0);
    do_write(BASE32 + 32'h10, 32'hDEAD_0002, 4'd2, 1'b1);
    do_write(BASE32 + SPAN + 32'h10, 32'hDEAD_0003, 4'd2, 1'b0);
    do_read(BASE32 + 32'h10, 32'h0000_0010, 0);

    // Reset while a response is pending.
    do_write(BASE32 + 32'h40, 32'hCAFE_F00D, 4'd2, 1'b0);
    send_req(mk_pkt(8'h02, 4'd2, 1'b0, BASE32 + 32'h40, 32'h0000_0999, 128'h0));
    repeat (EXP_LAT) begin
      @(posedge clk); #1;
    end
    check_eq("pre_reset_valid", 256'(umi_resp_valid), 256'(1));
    nreset = 1'b0;
    @(posedge clk); #1;
    exp_sticky = 1'b0;
    exp_code   = 2'd0;
    check_eq("mid_reset_valid", 256'(umi_resp_valid), 256'(0));
    check_eq("mid_reset_pkt", umi_resp_packet, 256'(0));
    check_eq("mid_reset_ready", 256'(umi_req_ready), 256'(0));
    check_err("mid_reset");
    nreset = 1'b1;
    @(posedge clk); #1;
    check_eq("post_reset_ready", 256'(umi_req_ready), 256'(1));
    expect_silent("post_reset_noresp", 2);
    do_read(BASE32 + 32'h40, 32'h0000_0040, 0);
    do_read(BASE32 + 32'h10, 32'h0000_0011, 2);

    check_eq("exp_q_empty", 256'(exp_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
